axi4_rd_arbiter: RTL
====================

# axi4_rd_arbiter

Shares one AXI4 master read path among `NUM_REQ` AXI4 read requesters using round-robin arbitration, with one burst in flight at a time. It sits between several DMA/descriptor engines and a single memory-side AXI4 port (HBM/DDR or an interconnect slave). The block sequences each transaction as address phase, then data phase, then release. It steers R beats back to the owner of the burst, so requesters need no ID remapping.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requester ports, 2..8.
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width.
- `ID_WIDTH`, 4: AXI ID width, identical on all ports.

Ports:
- `ACLK`, in, 1: the single clock.
- `ARESET`, in, 1: synchronous, active-high reset.
- `s_axi[NUM_REQ]`, `axi4.slave` modport array: requester ports. Only the AR and R channels are used.
- `m_axi`, `axi4.master` modport: the shared memory-side port.
- `grant_cnt[NUM_REQ]`, out, 32 each: count of completed bursts per requester.

The `ACLK`/`ARESETN` members inside the interfaces are ignored; the block uses only the module ports.

## Operation
- FSM states: `IDLE`, `ADDR`, `DATA`.
- **IDLE:**
  - If any `s_axi[i].ARVALID` is high, register `gnt` as the first asserted index at or after `rr_ptr`, searching upward with wrap.
  - Then go to `ADDR`.
- **ADDR:**
  - `m_axi.AR*` (ADDR, BURST, CACHE, ID, LEN, LOCK, PROT, QOS, REGION, SIZE) is a combinational mux of `s_axi[gnt]`.
  - `m_axi.ARVALID = s_axi[gnt].ARVALID`.
  - `s_axi[gnt].ARREADY = m_axi.ARREADY`. All other ARREADY are 0.
  - On `ARVALID & ARREADY`, go to `DATA`.
- **DATA:**
  - `s_axi[gnt].R*` = `m_axi.R*`, including RVALID, RDATA, RID, RRESP and RLAST.
  - `m_axi.RREADY = s_axi[gnt].RREADY`.
  - RVALID to every other port is 0.
  - On `RVALID & RREADY & RLAST`:
    - `rr_ptr <= (gnt+1) mod NUM_REQ`
    - `grant_cnt[gnt]++` (wraps at 2^32)
    - go to `IDLE`.
- Requester ports in non-owner or non-data states see `ARREADY=0` and `RVALID=0`.
- Write-channel tie-offs:
  - All `s_axi` AWREADY, WREADY and BVALID = 0.
  - `m_axi` AWVALID, WVALID and BREADY = 0.
  - Other `m_axi` AW/W fields = 0.
- A requester that drops ARVALID in `ADDR` breaks AXI protocol. The block still holds the grant until that requester raises ARVALID and the handshake completes. This is a documented hazard; there is no timeout.
- Burst length is not checked. Completion is decided only by RLAST.

## Timing
- Reset values:
  - state = `IDLE`, `gnt` = 0, `rr_ptr` = 0, all `grant_cnt` = 0.
  - All VALID/READY outputs = 0. All data outputs = 0, because the muxes are gated by state.
- Latency:
  - First-seen `s_axi[i].ARVALID` in `IDLE` leads to `m_axi.ARVALID` one cycle later.
  - After the RLAST handshake, the next grant is decided in `IDLE` the following cycle. Minimum dead time between bursts is 2 cycles (the `IDLE` cycle plus the `ADDR` entry cycle).
- Pass-through: `ADDR` and `DATA` are combinational. There is zero added cycle per beat, and the block supports full-throughput R beats.
- Simultaneous requests: resolved by `rr_ptr`. Each requester waits at most `NUM_REQ-1` bursts.
- A single-beat burst (`ARLEN=0`, RLAST on the first beat) behaves identically.
- Reset asserted mid-burst: the FSM returns to `IDLE` next edge and all handshakes drop. Outstanding R beats from the memory side are the system's responsibility; reset the slave together with this block.

## Structure
- Package `axi_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t`
  - `localparam` AXI burst constants (`BURST_INCR = 2'b01`)
  - `function` `clog2`-based index width helper.
- Sub-module `rr_pick`, parameterized on N:
  - inputs `req[N]` and `ptr`; outputs `idx` and `any`.
  - Purely combinational, using a double-width masked priority encoder.
  - Instantiated once.
- Top module holds the FSM, `gnt`/`rr_ptr` registers, AR/R muxes, tie-offs and counters.

## Test plan
- **Reset values:** hold `ARESET` for 5 cycles → all READY/VALID outputs are 0, state is `IDLE`, all `grant_cnt` are 0.
- **Single request:** port 2 requests `ARADDR=0x1000`, `ARLEN=3`, `ARID=5` → `m_axi` mirrors these 1 cycle later. 4 R beats with `RID=5` appear only on port 2. `grant_cnt[2]=1`.
- **All ports at once:** all 4 ports request `ARLEN=0` at the same time → grants are issued in order 0,1,2,3. Repeating the pattern gives 0,1,2,3 again.
- **Pointer rotation:** port 1 finishes a burst, then ports 0 and 1 request together → port 0 is granted first because `rr_ptr=2` wraps around to 0.
- **Backpressure:** `m_axi.ARREADY` low for 7 cycles, then `s_axi[gnt].RREADY` toggled every other beat on `ARLEN=7` → no beat is lost or duplicated, RLAST arrives on beat 8, and the FSM returns to `IDLE`.
- **Reset mid-burst:** assert `ARESET` during beat 3 of 8 → next cycle all outputs are 0, `grant_cnt` is cleared, and a new request is served normally afterwards.

Source files
------------

// File: rtl/axi4_rd_arbiter_pkg.sv
// Shared types, AXI burst encodings and sizing helpers for the read arbiter.
package axi_arb_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // AR attributes that travel with the address but are never interpreted here.
   // Field order matches the concatenation used when the top packs a port.
   typedef struct packed {
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic       lock;
      logic [3:0] cache;
      logic [2:0] prot;
      logic [3:0] qos;
      logic [3:0] region;
   } ar_attr_t;

   // Width of an index into n ports, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi4_rd_arbiter_if.sv
// AXI4 bundle shared by requesters and the memory-side port.
interface axi4 #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input logic ACLK,
   input logic ARESETN
);
   logic [ID_WIDTH-1:0]     ARID;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic [7:0]              ARLEN;
   logic [2:0]              ARSIZE;
   logic [1:0]              ARBURST;
   logic                    ARLOCK;
   logic [3:0]              ARCACHE;
   logic [2:0]              ARPROT;
   logic [3:0]              ARQOS;
   logic [3:0]              ARREGION;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [ID_WIDTH-1:0]     RID;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RLAST;
   logic                    RVALID;
   logic                    RREADY;
   logic [ID_WIDTH-1:0]     AWID;
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic [7:0]              AWLEN;
   logic [2:0]              AWSIZE;
   logic [1:0]              AWBURST;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WLAST;
   logic                    WVALID;
   logic                    WREADY;
   logic [ID_WIDTH-1:0]     BID;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;

   modport master (
      input  ACLK, ARESETN,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY,
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY
   );

   modport slave (
      input  ACLK, ARESETN,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY,
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY
   );
endinterface

// File: rtl/axi4_rd_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping upward.
module rr_pick
   import axi_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [N-1:0]   hi_mask;
   logic [2*N-1:0] dbl;

   // Lower copy keeps only requests at or above ptr; upper copy supplies the wrap.
   // Scanning downward lets the lowest set bit of the doubled vector win.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < N; i++) hi_mask[i] = (i >= int'(ptr));
      dbl = {req, req & hi_mask};
      idx = '0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (dbl[j]) idx = (j >= N) ? IW'(j - N) : IW'(j);
      end
      any = |req;
   end
endmodule

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ requesters,
// one burst in flight, R beats steered back to the burst owner.
module axi4_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic        ACLK,
   input  logic        ARESET,
   axi4.slave          s_axi [NUM_REQ],
   axi4.master         m_axi,
   output logic [31:0] grant_cnt [NUM_REQ]
);
   localparam int IW = idx_width(NUM_REQ);

   arb_state_t            state, state_nxt;
   logic [IW-1:0]         gnt, rr_ptr, pick_idx;
   logic                  pick_any;
   logic [NUM_REQ-1:0]    req_vec, rready_vec;
   logic [ADDR_WIDTH-1:0] s_araddr [NUM_REQ];
   logic [ID_WIDTH-1:0]   s_arid   [NUM_REQ];
   ar_attr_t              s_arattr [NUM_REQ];
   ar_attr_t              m_attr;
   logic                  sel_addr, sel_data, ar_fire, r_done;
   logic                  unused_m;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
      logic own_addr, own_data, unused_port;
      assign own_addr      = sel_addr & (gnt == IW'(i));
      assign own_data      = sel_data & (gnt == IW'(i));
      assign req_vec[i]    = s_axi[i].ARVALID;
      assign rready_vec[i] = s_axi[i].RREADY;
      assign s_araddr[i]   = s_axi[i].ARADDR;
      assign s_arid[i]     = s_axi[i].ARID;
      assign s_arattr[i]   = {s_axi[i].ARLEN, s_axi[i].ARSIZE, s_axi[i].ARBURST, s_axi[i].ARLOCK,
                              s_axi[i].ARCACHE, s_axi[i].ARPROT, s_axi[i].ARQOS, s_axi[i].ARREGION};
      assign s_axi[i].ARREADY = own_addr & m_axi.ARREADY;
      assign s_axi[i].RVALID  = own_data & m_axi.RVALID;
      assign s_axi[i].RDATA   = own_data ? m_axi.RDATA : '0;
      assign s_axi[i].RID     = own_data ? m_axi.RID   : '0;
      assign s_axi[i].RRESP   = own_data ? m_axi.RRESP : '0;
      assign s_axi[i].RLAST   = own_data & m_axi.RLAST;
      assign s_axi[i].AWREADY = 1'b0;
      assign s_axi[i].WREADY  = 1'b0;
      assign s_axi[i].BVALID  = 1'b0;
      assign s_axi[i].BID     = '0;
      assign s_axi[i].BRESP   = '0;
      assign unused_port = ^{s_axi[i].ACLK, s_axi[i].ARESETN, s_axi[i].AWID, s_axi[i].AWADDR,
                             s_axi[i].AWLEN, s_axi[i].AWSIZE, s_axi[i].AWBURST, s_axi[i].AWVALID,
                             s_axi[i].WDATA, s_axi[i].WSTRB, s_axi[i].WLAST, s_axi[i].WVALID,
                             s_axi[i].BREADY};
   end

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req (req_vec),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // State register.
   always_ff @(posedge ACLK) begin
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // Address phase, then data phase until the owner accepts RLAST, then release.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = ADDR;
         ADDR:    if (ar_fire)  state_nxt = DATA;
         DATA:    if (r_done)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Phase selects and the two handshake events the FSM waits on.
   always_comb begin
      sel_addr = (state == ADDR);
      sel_data = (state == DATA);
      ar_fire  = sel_addr & req_vec[gnt] & m_axi.ARREADY;
      r_done   = sel_data & m_axi.RVALID & rready_vec[gnt] & m_axi.RLAST;
   end

   // Latch the winner when leaving IDLE; advance the pointer past it on completion.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         gnt    <= '0;
         rr_ptr <= '0;
      end else begin
         if (state == IDLE && pick_any) gnt <= pick_idx;
         if (r_done) rr_ptr <= (gnt == IW'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
      end
   end

   // Per-requester completed-burst counters, free-running with natural wrap.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      end else if (r_done) begin
         grant_cnt[gnt] <= grant_cnt[gnt] + 32'd1;
      end
   end

   assign m_attr          = sel_addr ? s_arattr[gnt] : '0;
   assign m_axi.ARVALID   = sel_addr & req_vec[gnt];
   assign m_axi.ARADDR    = sel_addr ? s_araddr[gnt] : '0;
   assign m_axi.ARID      = sel_addr ? s_arid[gnt]   : '0;
   assign m_axi.ARLEN     = m_attr.len;
   assign m_axi.ARSIZE    = m_attr.size;
   assign m_axi.ARBURST   = m_attr.burst;
   assign m_axi.ARLOCK    = m_attr.lock;
   assign m_axi.ARCACHE   = m_attr.cache;
   assign m_axi.ARPROT    = m_attr.prot;
   assign m_axi.ARQOS     = m_attr.qos;
   assign m_axi.ARREGION  = m_attr.region;
   assign m_axi.RREADY    = sel_data & rready_vec[gnt];

   assign m_axi.AWID      = '0;
   assign m_axi.AWADDR    = '0;
   assign m_axi.AWLEN     = '0;
   assign m_axi.AWSIZE    = '0;
   assign m_axi.AWBURST   = '0;
   assign m_axi.AWVALID   = 1'b0;
   assign m_axi.WDATA     = '0;
   assign m_axi.WSTRB     = '0;
   assign m_axi.WLAST     = 1'b0;
   assign m_axi.WVALID    = 1'b0;
   assign m_axi.BREADY    = 1'b0;

   assign unused_m = ^{m_axi.ACLK, m_axi.ARESETN, m_axi.AWREADY, m_axi.WREADY,
                       m_axi.BID, m_axi.BRESP, m_axi.BVALID};
endmodule
